// File: rtl/sram_arbiter_pkg.sv
// Shared constants for the instruction/data SRAM arbiter: response-owner
// encoding, default starvation limit and the saturating starve-counter step.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    localparam int unsigned STARVE_LIMIT_DEF = 3;

    function automatic logic [1:0] starve_inc(input logic [1:0] cnt, input logic [1:0] limit);
        logic [1:0] res;
        if (cnt >= limit) begin
            res = limit;
        end else begin
            res = cnt + 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM bus bundle; the arbiter takes the slave view, a
// driver/bench takes the master view.
interface sram_arbiter_if;

    logic        inst_req;
    logic [3:0]  inst_we;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic [3:0]  data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport slave (
        input  inst_req, inst_we, inst_addr, inst_wdata,
        input  data_req, data_we, data_addr, data_wdata,
        input  sram_rdata,
        output inst_gnt, inst_rvalid, inst_rdata,
        output data_gnt, data_rvalid, data_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output inst_req, inst_we, inst_addr, inst_wdata,
        output data_req, data_we, data_addr, data_wdata,
        output sram_rdata,
        input  inst_gnt, inst_rvalid, inst_rdata,
        input  data_gnt, data_rvalid, data_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );

endinterface

// File: rtl/sram_arbiter_arb2_starve.sv
// Two-way grant: data has priority, but inst wins once data has taken
// STARVE_LIMIT consecutive grants while inst was waiting.
module arb2_starve
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic inst_req_i,
    input  logic data_req_i,
    output logic inst_gnt_o,
    output logic data_gnt_o
);

    localparam logic [1:0] LIMIT_C = 2'(STARVE_LIMIT);

    logic [1:0] starve_q;
    logic [1:0] starve_d;

    // Grant decision and starve-counter next state
    always_comb begin
        inst_gnt_o = 1'b0;
        data_gnt_o = 1'b0;
        starve_d   = starve_q;
        if (reset) begin
            inst_gnt_o = 1'b0;
            data_gnt_o = 1'b0;
        end else if (data_req_i && !(inst_req_i && (starve_q == LIMIT_C))) begin
            data_gnt_o = 1'b1;
        end else if (inst_req_i) begin
            inst_gnt_o = 1'b1;
        end else begin
            inst_gnt_o = 1'b0;
        end

        // A waiting inst that goes away or gets served forgets its history
        if (!inst_req_i || inst_gnt_o) begin
            starve_d = 2'd0;
        end else if (data_gnt_o) begin
            starve_d = starve_inc(starve_q, LIMIT_C);
        end else begin
            starve_d = starve_q;
        end
    end

    // Starve counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= 2'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter between an instruction and a data requester with
// zero-wait grants and a one-cycle response pipeline.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    sram_arbiter_if.slave  bus
);

    logic        inst_gnt_s;
    logic        data_gnt_s;
    owner_e      owner_q;
    owner_e      owner_d;
    logic        rd_q;
    logic        rd_d;
    logic [31:0] inst_rdata_q;
    logic [31:0] inst_rdata_d;
    logic [31:0] data_rdata_q;
    logic [31:0] data_rdata_d;
    logic [3:0]  sram_we_s;
    logic [31:0] sram_addr_s;
    logic [31:0] sram_wdata_s;

    arb2_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .inst_req_i (bus.inst_req),
        .data_req_i (bus.data_req),
        .inst_gnt_o (inst_gnt_s),
        .data_gnt_o (data_gnt_s)
    );

    // Route the winner's request to the SRAM; idle bus is all zeros
    always_comb begin
        sram_we_s    = 4'h0;
        sram_addr_s  = 32'h0000_0000;
        sram_wdata_s = 32'h0000_0000;
        if (data_gnt_s) begin
            sram_we_s    = bus.data_we;
            sram_addr_s  = bus.data_addr;
            sram_wdata_s = bus.data_wdata;
        end else if (inst_gnt_s) begin
            sram_we_s    = bus.inst_we;
            sram_addr_s  = bus.inst_addr;
            sram_wdata_s = bus.inst_wdata;
        end else begin
            sram_we_s    = 4'h0;
        end
    end

    // Next owner of the response slot and read-data capture
    always_comb begin
        owner_d      = OWN_NONE;
        rd_d         = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        if (data_gnt_s) begin
            owner_d = OWN_DATA;
            rd_d    = (bus.data_we == 4'h0);
        end else if (inst_gnt_s) begin
            owner_d = OWN_INST;
            rd_d    = (bus.inst_we == 4'h0);
        end else begin
            owner_d = OWN_NONE;
        end

        // sram_rdata is only meaningful in the cycle after a read grant
        case (owner_q)
            OWN_INST: begin
                if (rd_q) begin
                    inst_rdata_d = bus.sram_rdata;
                end else begin
                    inst_rdata_d = inst_rdata_q;
                end
            end
            OWN_DATA: begin
                if (rd_q) begin
                    data_rdata_d = bus.sram_rdata;
                end else begin
                    data_rdata_d = data_rdata_q;
                end
            end
            default: begin
                inst_rdata_d = inst_rdata_q;
                data_rdata_d = data_rdata_q;
            end
        endcase
    end

    // Response pipeline and rdata holding registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q      <= OWN_NONE;
            rd_q         <= 1'b0;
            inst_rdata_q <= 32'h0000_0000;
            data_rdata_q <= 32'h0000_0000;
        end else begin
            owner_q      <= owner_d;
            rd_q         <= rd_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign bus.inst_gnt    = inst_gnt_s;
    assign bus.data_gnt    = data_gnt_s;
    assign bus.sram_en     = inst_gnt_s | data_gnt_s;
    assign bus.sram_we     = sram_we_s;
    assign bus.sram_addr   = sram_addr_s;
    assign bus.sram_wdata  = sram_wdata_s;
    assign bus.inst_rvalid = (owner_q == OWN_INST);
    assign bus.data_rvalid = (owner_q == OWN_DATA);
    // Read data is visible in the response cycle itself, then held
    assign bus.inst_rdata  = inst_rdata_d;
    assign bus.data_rdata  = data_rdata_d;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with hand-computed expectations.
module tb_sram_arbiter;

    logic clk;
    logic reset;
    int   vec_cnt;
    int   err_cnt;

    sram_arbiter_if bus ();

    sram_arbiter #(
        .STARVE_LIMIT (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.inst_req   = 1'b0;
        bus.inst_we    = 4'h0;
        bus.inst_addr  = 32'h0;
        bus.inst_wdata = 32'h0;
        bus.data_req   = 1'b0;
        bus.data_we    = 4'h0;
        bus.data_addr  = 32'h0;
        bus.data_wdata = 32'h0;
        bus.sram_rdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        bus.inst_req = 1'b1;
        bus.data_req = 1'b1;
        bus.data_addr = 32'h0000_0abc;
        next_cycle();
        next_cycle();
        vec_cnt++;
        if ({bus.inst_gnt, bus.data_gnt, bus.sram_en} !== 3'b000) begin
            err_cnt++;
            $display("FAIL reset_gnt: got gnt/en %b expected 000", {bus.inst_gnt, bus.data_gnt, bus.sram_en});
        end
        vec_cnt++;
        if ({bus.sram_we, bus.sram_addr, bus.sram_wdata} !== 68'h0) begin
            err_cnt++;
            $display("FAIL reset_sram: got addr %h expected 0", bus.sram_addr);
        end
        vec_cnt++;
        if ({bus.inst_rvalid, bus.data_rvalid, bus.inst_rdata, bus.data_rdata} !== 66'h0) begin
            err_cnt++;
            $display("FAIL reset_resp: got rvalid %b%b rdata %h/%h expected zeros",
                     bus.inst_rvalid, bus.data_rvalid, bus.inst_rdata, bus.data_rdata);
        end
        drive_idle();
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_inst_read();
        bus.inst_req  = 1'b1;
        bus.inst_we   = 4'h0;
        bus.inst_addr = 32'h1c00_0000;
        #1;
        vec_cnt++;
        if ({bus.inst_gnt, bus.data_gnt, bus.sram_en, bus.sram_we} !== 7'b1010000) begin
            err_cnt++;
            $display("FAIL inst_grant: got gnt %b%b en %b we %h expected 1 0 1 0",
                     bus.inst_gnt, bus.data_gnt, bus.sram_en, bus.sram_we);
        end
        vec_cnt++;
        if (bus.sram_addr !== 32'h1c00_0000) begin
            err_cnt++;
            $display("FAIL inst_addr: got %h expected 1c000000", bus.sram_addr);
        end
        next_cycle();
        drive_idle();
        bus.sram_rdata = 32'ha5a5_1234;
        #1;
        vec_cnt++;
        if ({bus.inst_rvalid, bus.data_rvalid, bus.inst_rdata} !== {2'b10, 32'ha5a5_1234}) begin
            err_cnt++;
            $display("FAIL inst_resp: got rvalid %b%b rdata %h expected 10 a5a51234",
                     bus.inst_rvalid, bus.data_rvalid, bus.inst_rdata);
        end
        vec_cnt++;
        if ({bus.sram_en, bus.sram_addr} !== 33'h0) begin
            err_cnt++;
            $display("FAIL idle_bus: got en %b addr %h expected 0", bus.sram_en, bus.sram_addr);
        end
        next_cycle();
        bus.sram_rdata = 32'h0bad_0bad;
        #1;
        vec_cnt++;
        if ({bus.inst_rvalid, bus.inst_rdata} !== {1'b0, 32'ha5a5_1234}) begin
            err_cnt++;
            $display("FAIL inst_hold: got rvalid %b rdata %h expected 0 a5a51234",
                     bus.inst_rvalid, bus.inst_rdata);
        end
        drive_idle();
        next_cycle();
    endtask

    task automatic test_data_write();
        bus.data_req   = 1'b1;
        bus.data_we    = 4'hf;
        bus.data_addr  = 32'h0000_0100;
        bus.data_wdata = 32'hdead_beef;
        #1;
        vec_cnt++;
        if ({bus.data_gnt, bus.inst_gnt, bus.sram_we, bus.sram_addr, bus.sram_wdata}
            !== {2'b10, 4'hf, 32'h0000_0100, 32'hdead_beef}) begin
            err_cnt++;
            $display("FAIL data_write_bus: got gnt %b%b we %h addr %h wdata %h expected 10 f 100 deadbeef",
                     bus.data_gnt, bus.inst_gnt, bus.sram_we, bus.sram_addr, bus.sram_wdata);
        end
        next_cycle();
        drive_idle();
        bus.sram_rdata = 32'h1111_1111;
        #1;
        vec_cnt++;
        if ({bus.data_rvalid, bus.inst_rvalid, bus.data_rdata} !== {2'b10, 32'h0}) begin
            err_cnt++;
            $display("FAIL data_write_resp: got rvalid %b%b rdata %h expected 10 00000000",
                     bus.data_rvalid, bus.inst_rvalid, bus.data_rdata);
        end
        drive_idle();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h0000_0040;
        #1;
        vec_cnt++;
        if (bus.inst_gnt !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b_inst_gnt: got %b expected 1", bus.inst_gnt);
        end
        next_cycle();
        drive_idle();
        bus.data_req   = 1'b1;
        bus.data_addr  = 32'h0000_0080;
        bus.sram_rdata = 32'h1111_0001;
        #1;
        vec_cnt++;
        if ({bus.inst_rvalid, bus.data_rvalid, bus.inst_rdata} !== {2'b10, 32'h1111_0001}) begin
            err_cnt++;
            $display("FAIL b2b_inst_resp: got rvalid %b%b rdata %h expected 10 11110001",
                     bus.inst_rvalid, bus.data_rvalid, bus.inst_rdata);
        end
        vec_cnt++;
        if ({bus.data_gnt, bus.sram_addr} !== {1'b1, 32'h0000_0080}) begin
            err_cnt++;
            $display("FAIL b2b_data_gnt: got gnt %b addr %h expected 1 80", bus.data_gnt, bus.sram_addr);
        end
        next_cycle();
        drive_idle();
        bus.sram_rdata = 32'h2222_0002;
        #1;
        vec_cnt++;
        if ({bus.data_rvalid, bus.inst_rvalid, bus.data_rdata, bus.inst_rdata}
            !== {2'b10, 32'h2222_0002, 32'h1111_0001}) begin
            err_cnt++;
            $display("FAIL b2b_data_resp: got rvalid %b%b rdata %h inst %h expected 10 22220002 11110001",
                     bus.data_rvalid, bus.inst_rvalid, bus.data_rdata, bus.inst_rdata);
        end
        drive_idle();
        next_cycle();
    endtask

    // One cycle with the given requests; expect_data selects the expected winner
    task automatic arb_step(input string name, input int idx, input logic ireq,
                            input logic dreq, input logic expect_data);
        bus.inst_req  = ireq;
        bus.data_req  = dreq;
        bus.inst_addr = 32'h0000_1000;
        bus.data_addr = 32'h0000_2000;
        #1;
        vec_cnt++;
        if ({bus.data_gnt, bus.inst_gnt, bus.sram_addr}
            !== {expect_data, ~expect_data, (expect_data ? 32'h0000_2000 : 32'h0000_1000)}) begin
            err_cnt++;
            $display("FAIL %s[%0d]: got data_gnt %b inst_gnt %b addr %h expected data_gnt %b",
                     name, idx, bus.data_gnt, bus.inst_gnt, bus.sram_addr, expect_data);
        end
        next_cycle();
    endtask

    task automatic test_starve();
        logic [7:0] exp_d;
        exp_d = 8'b1110_1110;
        for (int i = 0; i < 8; i++) begin
            arb_step("starve_seq", i, 1'b1, 1'b1, exp_d[7-i]);
        end
        drive_idle();
        next_cycle();
    endtask

    task automatic test_starve_clear();
        logic [6:0] ireq_v;
        logic [6:0] exp_d;
        ireq_v = 7'b1101111;
        exp_d  = 7'b1111110;
        for (int i = 0; i < 7; i++) begin
            arb_step("starve_clear", i, ireq_v[6-i], 1'b1, exp_d[6-i]);
        end
        drive_idle();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        arb_step("rst_pre", 0, 1'b1, 1'b1, 1'b1);
        arb_step("rst_pre", 1, 1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        bus.sram_rdata = 32'h5555_5555;
        #1;
        vec_cnt++;
        if ({bus.inst_rvalid, bus.data_rvalid, bus.inst_gnt, bus.data_gnt,
             bus.inst_rdata, bus.data_rdata} !== 68'h0) begin
            err_cnt++;
            $display("FAIL rst_mid: got rvalid %b%b gnt %b%b rdata %h/%h expected zeros",
                     bus.inst_rvalid, bus.data_rvalid, bus.inst_gnt, bus.data_gnt,
                     bus.inst_rdata, bus.data_rdata);
        end
        next_cycle();
        reset = 1'b0;
        drive_idle();
        bus.sram_rdata = 32'h5555_5555;
        next_cycle();
        vec_cnt++;
        if ({bus.inst_rvalid, bus.data_rvalid, bus.data_rdata} !== 34'h0) begin
            err_cnt++;
            $display("FAIL rst_after: got rvalid %b%b data_rdata %h expected 00 00000000",
                     bus.inst_rvalid, bus.data_rvalid, bus.data_rdata);
        end
        for (int i = 0; i < 4; i++) begin
            arb_step("rst_restart", i, 1'b1, 1'b1, (i < 3));
        end
        drive_idle();
        next_cycle();
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        reset   = 1'b1;
        drive_idle();
        test_reset();
        test_inst_read();
        test_data_write();
        test_back_to_back();
        test_starve();
        test_starve_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
